// File: rtl/data_mem_sram_if.sv
// ============================================================================
//  Module   : data_mem_sram_if
//  Purpose  : Request/response bus between the memory stage and data_mem_sram.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface data_mem_sram_if;
    logic        req_i;
    logic [63:0] addr_i;
    logic        wr_i;
    logic [63:0] wr_data_i;
    logic [7:0]  mask_i;
    logic        ready_o;
    logic        resp_valid_o;
    logic [63:0] rd_data_o;
    logic        rd_ready_i;

    modport master (
        output req_i, addr_i, wr_i, wr_data_i, mask_i, rd_ready_i,
        input  ready_o, resp_valid_o, rd_data_o
    );

    modport slave (
        input  req_i, addr_i, wr_i, wr_data_i, mask_i, rd_ready_i,
        output ready_o, resp_valid_o, rd_data_o
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_sram.sv
// ============================================================================
//  Module   : data_mem_sram
//  Purpose  : 64-bit byte-masked data memory with fixed-latency in-order
//             responses, FWFT response FIFO and credit-based flow control.
//             Optional macro DMEM_STALL_INJECT_EN adds LFSR ready stalls.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_sram #(
    parameter int          DEPTH      = 4096,
    parameter int          LATENCY    = 2,
    parameter int          RESP_DEPTH = 4,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    data_mem_sram_if.slave    bus
);

    localparam int             AW        = $clog2(DEPTH);
    localparam int             PW        = $clog2(RESP_DEPTH);
    localparam int             CW        = PW + 1;
    localparam logic [CW-1:0]  C_CREDITS = CW'(RESP_DEPTH);
    localparam logic [CW-1:0]  C_ONE     = CW'(1);

    logic          accept;
    logic          ready;
    logic          stall;
    logic [AW-1:0] idx;
    logic          unused_addr;

    assign idx         = bus.addr_i[AW+2:3];
    assign unused_addr = ^{bus.addr_i[63:AW+3], bus.addr_i[2:0]};
    assign accept      = bus.req_i & ready;

    // ---------------- BRAM ----------------
    logic [63:0] mem_q [DEPTH];
    logic [63:0] bram_rd_q;

    always_ff @(posedge clk) begin
        if (accept && bus.wr_i) begin
            for (int k = 0; k < 8; k++) begin
                if (bus.mask_i[k]) begin
                    mem_q[idx][8*k +: 8] <= bus.wr_data_i[8*k +: 8];
                end
            end
        end
        if (accept && !bus.wr_i) begin
            bram_rd_q <= mem_q[idx];
        end
    end

    // Stage 0 is the BRAM read register itself.
    logic        s0_valid_q;
    logic        s0_wr_q;
    logic [63:0] s0_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_wr_q    <= 1'b0;
        end else begin
            s0_valid_q <= accept;
            s0_wr_q    <= bus.wr_i;
        end
    end

    assign s0_data = s0_wr_q ? 64'h0 : bram_rd_q;

    logic        pipe_valid;
    logic [63:0] pipe_data;

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [LATENCY-2:0] v_q;
            logic [63:0]        d_q [LATENCY-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= s0_valid_q;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        v_q[k] <= v_q[k-1];
                    end
                end
                d_q[0] <= s0_data;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    d_q[k] <= d_q[k-1];
                end
            end

            assign pipe_valid = v_q[LATENCY-2];
            assign pipe_data  = d_q[LATENCY-2];
        end else begin : g_direct
            assign pipe_valid = s0_valid_q;
            assign pipe_data  = s0_data;
        end
    endgenerate

    // ---------------- Response FIFO (first-word fall-through) ----------------
    logic [63:0]   fifo_q [RESP_DEPTH];
    logic [CW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          fifo_empty;
    logic          resp_valid;
    logic [63:0]   resp_data;
    logic          pop;
    logic          push;
    logic          fifo_pop;

    assign fifo_empty = (wptr_q == rptr_q);
    assign resp_valid = !reset && (!fifo_empty || pipe_valid);
    assign resp_data  = fifo_empty ? pipe_data : fifo_q[rptr_q[PW-1:0]];
    assign pop        = resp_valid && bus.rd_ready_i;
    assign push       = pipe_valid && !(fifo_empty && pop);
    assign fifo_pop   = pop && !fifo_empty;
    assign wptr_d     = wptr_q + CW'(push);
    assign rptr_d     = rptr_q + CW'(fifo_pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q[PW-1:0]] <= pipe_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // ---------------- Credit counter ----------------
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + C_ONE;
        end else if (!accept && pop) begin
            count_d = count_q - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef DMEM_STALL_INJECT_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    logic [15:0] unused_seed;
    assign unused_seed = STALL_SEED;
    assign stall       = 1'b0;
`endif

    assign ready            = !reset && (count_q < C_CREDITS) && !stall;
    assign bus.ready_o      = ready;
    assign bus.resp_valid_o = resp_valid;
    assign bus.rd_data_o    = resp_valid ? resp_data : 64'h0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_sram.sv
// ============================================================================
//  Module   : tb_data_mem_sram
//  Purpose  : Self-checking bench for data_mem_sram (vectors, corner
//             sequences and random traffic against a queue-based model).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_sram;
    localparam int LAT   = 2;
    localparam int RD    = 4;
    localparam int DEPTH = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_sram_if bus();

    data_mem_sram #(
        .DEPTH(DEPTH), .LATENCY(LAT), .RESP_DEPTH(RD), .STALL_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int errors = 0, checks = 0, cyc = 0, pops = 0;
    int stat_tot = 0, stat_low = 0;
    bit stat_en = 1'b0;

    typedef struct { logic [63:0] d; int due; bit known; } exp_t;
    exp_t        expq[$];
    logic [63:0] mdl [longint];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint widx(input logic [63:0] a);
        return longint'((a >> 3) % DEPTH);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: responses come back in order, each due LAT cycles after accept.
    int          m_nrdy;
    exp_t        m_e;
    logic [63:0] m_w;
    longint      m_i;
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_ready", bus.ready_o, 0);
            chk("rst_resp_valid", bus.resp_valid_o, 0);
            chk("rst_rd_data", bus.rd_data_o, 0);
            expq.delete();
        end else begin
            m_nrdy = 0;
            foreach (expq[k]) if (expq[k].due <= cyc) m_nrdy++;
            chk("resp_valid", bus.resp_valid_o, (m_nrdy > 0));
            if (!bus.resp_valid_o) chk("idle_rd_data", bus.rd_data_o, 0);
`ifdef DMEM_STALL_INJECT_EN
            if (expq.size() >= RD) chk("ready_when_full", bus.ready_o, 0);
            else if (stat_en) begin
                stat_tot++;
                if (!bus.ready_o) stat_low++;
            end
`else
            chk("ready_credit", bus.ready_o, (expq.size() < RD));
`endif
            if (bus.resp_valid_o && bus.rd_ready_i && expq.size() > 0) begin
                m_e = expq.pop_front();
                if (m_e.known) chk("resp_data", bus.rd_data_o, m_e.d);
                pops++;
            end
            if (bus.req_i && bus.ready_o) begin
                m_i       = widx(bus.addr_i);
                m_e.due   = cyc + LAT;
                m_e.known = 1'b1;
                m_e.d     = 64'h0;
                if (bus.wr_i) begin
                    if (mdl.exists(m_i) || bus.mask_i == 8'hFF) begin
                        m_w = mdl.exists(m_i) ? mdl[m_i] : 64'h0;
                        for (int k = 0; k < 8; k++)
                            if (bus.mask_i[k]) m_w[8*k +: 8] = bus.wr_data_i[8*k +: 8];
                        mdl[m_i] = m_w;
                    end
                end else if (mdl.exists(m_i)) begin
                    m_e.d = mdl[m_i];
                end else begin
                    m_e.known = 1'b0;
                end
                expq.push_back(m_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input bit wr, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] m, output logic [63:0] got);
        bit ok;
        got = 64'h0;
        bus.req_i = 1'b1; bus.wr_i = wr; bus.addr_i = a;
        bus.wr_data_i = d; bus.mask_i = m; bus.rd_ready_i = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.ready_o) ok = 1'b1;
            tick();
        end
        bus.req_i = 1'b0;
        chk("accept_in_time", 64'(ok), 1);
        if (!ok) return;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.resp_valid_o) begin
                got = bus.rd_data_o;
                ok  = 1'b1;
            end
            tick();
        end
        chk("resp_in_time", 64'(ok), 1);
    endtask

    task automatic drain(input string name);
        bus.req_i = 1'b0;
        bus.rd_ready_i = 1'b1;
        for (int k = 0; k < 60 && expq.size() > 0; k++) tick();
        chk(name, 64'(expq.size()), 0);
    endtask

    typedef struct {
        bit          wr;
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  m;
        logic [63:0] exp;
        string       name;
    } vec_t;
    vec_t vt[11];

    logic [63:0] got;
    int          acc;
    int          p0;

    initial begin
        vt[0]  = '{1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, "wr_full_resp"};
        vt[1]  = '{0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_7788, "rd_full"};
        vt[2]  = '{1, 64'h8000_0010, 64'h0000_0000_0000_00AA, 8'h01, 64'h0, "wr_byte_resp"};
        vt[3]  = '{0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122_3344_5566_77AA, "rd_byte_merge"};
        vt[4]  = '{1, 64'h8000_0018, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, "wr_full2_resp"};
        vt[5]  = '{1, 64'h8000_0018, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 64'h0, "wr_upper_resp"};
        vt[6]  = '{0, 64'h8000_0018, 64'h0, 8'h00, 64'hDEAD_BEEF_89AB_CDEF, "rd_upper_lanes"};
        vt[7]  = '{0, 64'h8000_8010, 64'h0, 8'h00, 64'h1122_3344_5566_77AA, "rd_index_wrap"};
        vt[8]  = '{0, 64'h8000_0017, 64'h0, 8'h00, 64'h1122_3344_5566_77AA, "rd_low_bits_ignored"};
        vt[9]  = '{1, 64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, "wr_nomask_resp"};
        vt[10] = '{0, 64'h8000_0018, 64'h0, 8'h00, 64'hDEAD_BEEF_89AB_CDEF, "rd_after_nomask"};

        // Reset held with a pending request: nothing may be accepted.
        bus.req_i = 1'b1; bus.wr_i = 1'b0; bus.addr_i = 64'h8000_0010;
        bus.wr_data_i = 64'h0; bus.mask_i = 8'h00; bus.rd_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.ready_o, 1);
        repeat (4) tick();

        for (int i = 0; i < 11; i++) begin
            do_op(vt[i].wr, vt[i].a, vt[i].d, vt[i].m, got);
            chk(vt[i].name, got, vt[i].exp);
        end

`ifndef DMEM_STALL_INJECT_EN
        // Write then read-after-write on consecutive cycles, exact response timing.
        bus.req_i = 1'b1; bus.wr_i = 1'b1; bus.addr_i = 64'h8000_0020;
        bus.wr_data_i = 64'h1122_3344_5566_7788; bus.mask_i = 8'hFF; bus.rd_ready_i = 1'b1;
        @(negedge clk); chk("raw_wr_accept", bus.ready_o, 1);
        tick();
        bus.wr_i = 1'b0;
        @(negedge clk); chk("raw_rd_accept", bus.ready_o, 1);
        tick();
        bus.req_i = 1'b0;
        @(negedge clk);
        chk("raw_wr_resp_valid", bus.resp_valid_o, 1);
        chk("raw_wr_resp_data", bus.rd_data_o, 0);
        tick();
        @(negedge clk);
        chk("raw_rd_resp_valid", bus.resp_valid_o, 1);
        chk("raw_rd_resp_data", bus.rd_data_o, 64'h1122_3344_5566_7788);
        tick();

        // Backpressure: six reads against a blocked consumer.
        for (int i = 0; i < 4; i++)
            do_op(1, 64'h8000_0100 + 64'(8*i), 64'hA0A0_0000_0000_0000 | 64'(i), 8'hFF, got);
        p0 = pops;
        acc = 0;
        bus.rd_ready_i = 1'b0; bus.wr_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.req_i = (acc < 6); bus.addr_i = 64'h8000_0100 + 64'(8*(acc % 4));
            @(negedge clk);
            if (bus.req_i && bus.ready_o) acc++;
            tick();
        end
        chk("bp_accepted_while_blocked", 64'(acc), 4);
        @(negedge clk);
        chk("bp_ready_low", bus.ready_o, 0);
        tick();
        bus.rd_ready_i = 1'b1;
        for (int c = 0; c < 40 && (acc < 6 || expq.size() > 0); c++) begin
            bus.req_i = (acc < 6); bus.addr_i = 64'h8000_0100 + 64'(8*(acc % 4));
            @(negedge clk);
            if (bus.req_i && bus.ready_o) acc++;
            tick();
        end
        bus.req_i = 1'b0;
        chk("bp_all_accepted", 64'(acc), 6);
        chk("bp_pop_count", 64'(pops - p0), 6);

        // Simultaneous accept and pop at three outstanding.
        bus.rd_ready_i = 1'b0; bus.req_i = 1'b1; bus.wr_i = 1'b0; bus.addr_i = 64'h8000_0100;
        repeat (3) tick();
        bus.rd_ready_i = 1'b1;
        @(negedge clk);
        chk("credit_ready_at3", bus.ready_o, 1);
        chk("credit_pop_valid", bus.resp_valid_o, 1);
        tick();
        bus.rd_ready_i = 1'b0;
        @(negedge clk);
        chk("credit_ready_stays", bus.ready_o, 1);
        tick();
        bus.req_i = 1'b0;
        @(negedge clk);
        chk("credit_ready_full", bus.ready_o, 0);
        tick();
        drain("credit_drain");

        // Reset with reads in flight.
        bus.rd_ready_i = 1'b0; bus.req_i = 1'b1; bus.addr_i = 64'h8000_0010;
        repeat (3) tick();
        bus.req_i = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        bus.rd_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_resp_after_reset", bus.resp_valid_o, 0);
            tick();
        end
        do_op(0, 64'h8000_0018, 64'h0, 8'h00, got);
        chk("data_kept_over_reset", got, 64'hDEAD_BEEF_89AB_CDEF);
`endif

        // Random traffic over a small window of preloaded words.
        for (int i = 0; i < 16; i++)
            do_op(1, 64'h8000_0200 + 64'(8*i), {$urandom, $urandom}, 8'hFF, got);
        stat_en = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            bus.req_i      = ($urandom_range(0, 3) != 0);
            bus.wr_i       = $urandom_range(0, 1) == 1;
            bus.addr_i     = 64'h8000_0200 + 64'(8*$urandom_range(0, 15)) + 64'($urandom_range(0, 7));
            bus.wr_data_i  = {$urandom, $urandom};
            bus.mask_i     = 8'($urandom);
            bus.rd_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        stat_en = 1'b0;
        drain("random_drain");
`ifdef DMEM_STALL_INJECT_EN
        $display("stall ratio: %0d of %0d cycles", stat_low, stat_tot);
        chk("stall_ratio_20_30", 64'((stat_low * 100 >= stat_tot * 20) && (stat_low * 100 <= stat_tot * 30)), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
